command_issue_control: RTL and testbench
========================================

Name: command_issue_control

Overview:
- Transmit-side counterpart of the PSL response path. Accepts command requests from the AFU command arbiter and allocates a free tag and a PSL credit for each one.
- Drives the PSL command interface with odd parity on tag, command code and effective address.
- Writes the per-tag command record into the tag table that the response path reads back.
- Recovers tags and credits from returned responses and drains cleanly when the AFU is disabled.

Parameters:
- NUM_TAGS, 32, number of tags in the pool; power of two, maximum 256.
- TAG_W, 8, PSL tag width.
- CREDIT_W, 9, signed width of the credit counter and of the response credit return.

Ports:
- clock  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- enabled_in  in  1  AFU running.
- ha_croom  in  8  PSL command room; sampled once on the enable edge.
- cmd_valid  in  1  request valid.
- cmd_ready  out  1  request accepted when cmd_valid is also high.
- cmd_com  in  13  PSL command code.
- cmd_ea  in  64  effective address.
- cmd_size  in  12  transfer size.
- cmd_abt  in  3  translation ordering.
- cmd_meta  in  32  CommandTagLine payload (cmd_type, cu_id, ...) stored per tag.
- resp_valid  in  1  response returned.
- resp_tag  in  8  returned tag.
- resp_credits  in  9  signed credit return.
- ah_cvalid, ah_ctag(8), ah_ctagpar(1), ah_com(13), ah_compar(1), ah_cea(64), ah_ceapar(1), ah_csize(12), ah_cabt(3), ah_cch(16)  out  PSL command bus.
- tag_wr_en  out  1  tag table write strobe.
- tag_wr_addr  out  8  tag table address.
- tag_wr_data  out  32  tag table record.
- outstanding  out  9  tags currently in flight.
- drain_done  out  1  one-cycle pulse when a drain completes.
- command_error  out  3  sticky error flags {credit_overflow, tag_double_free, tag_range}.

Behaviour:
- Reset (async, rst=1): state=DISABLED; credits=0; all tags free; every output 0; ah_ctagpar, ah_compar and ah_ceapar=1 (odd parity of zero).
- FSM states and transitions:
  - DISABLED: on enabled_in=1, credits<=ha_croom (zero-extended) and go to RUN.
  - RUN: on enabled_in=0, go to DRAIN.
  - DRAIN: when outstanding==0, pulse drain_done for one cycle and go to DISABLED.
  - DRAIN with enabled_in back to 1: stay in DRAIN until outstanding==0. Enable is then re-sampled in DISABLED and the credits re-latched from ha_croom.
- cmd_ready is combinational: state==RUN && credits>0 && any tag free. It does not depend on cmd_valid.
- Issue fires on cmd_valid && cmd_ready.
  - Allocated tag = lowest-index free tag, taken from the free mask before this cycle's response free is applied.
  - Next cycle: ah_cvalid=1 for exactly one cycle with registered fields, and tag_wr_en=1 with tag_wr_addr=tag, tag_wr_data=cmd_meta.
  - Latency 1. Back-to-back issue every cycle is allowed.
  - ah_cch=0.
- Parity: each parity bit is computed so that data plus parity bit has odd weight. Parity is computed on the registered value and driven in the same cycle as ah_cvalid.
- Credits: credits_next = credits − issue + (resp_valid ? sign-extended resp_credits : 0). Both terms apply in the same cycle.
  - If credits_next > latched room: set the credit_overflow flag and clamp credits to the room value.
  - Negative resp_credits are legal.
- Tag free: on resp_valid, tag resp_tag becomes free starting next cycle.
  - resp_tag ≥ NUM_TAGS: set the tag_range flag; no tag state change. The credit return is still applied.
  - Freeing a tag that is already free: set the tag_double_free flag; ignored.
  - Simultaneous allocate and free of different tags: both take effect.
  - A freed tag is not reallocated in the cycle it is freed.
- outstanding = NUM_TAGS − popcount(free mask). Updated in the same cycle as the free mask.
- Responses are accepted in every state, including DISABLED (they free tags and return credits).
- command_error flags are sticky until reset.

Decomposition:
- Shared package (AFU_PKG): PSL command code constants, the CommandTagLine typedef, the FSM state enum, and a CommandInterfaceOut struct grouping the ah_c* outputs.
- Sub-module: tag_pool_allocator, owning the free mask, the lowest-free priority encoder, the outstanding popcount and the free-error detection. Reuses the existing parity module (BITS=8/13/64) for the three parity bits.

Test Plan:
- Reset, then enabled_in=1 with ha_croom=4; issue 4 reads → ah_ctag=0,1,2,3 on consecutive cycles; cmd_ready=0 after the 4th (credits=0); outstanding=4.
- Parity: cmd_com=0x0A00, cmd_ea=0x0000_0000_0000_0001 issued as tag 0 → ah_ctagpar=1, ah_compar=1, ah_ceapar=0.
- Simultaneous free and allocate: with credits=1 and tag 0 outstanding, resp_valid tag=0 with credits=+1 plus cmd_valid in the same cycle → new command gets tag 1; credits=1; tag 0 free next cycle.
- Tag exhaustion: NUM_TAGS=32, ha_croom=64; issue 32 commands → cmd_ready=0 with credits=32; one response frees tag 5 → the next command gets tag 5.
- Errors: resp_tag=40 → command_error=3'b001; then free already-free tag 2 → 3'b011; then resp_credits=+5 at full room → 3'b111, and credits stay at room.
- Drain: 3 tags outstanding, enabled_in=0 → cmd_ready=0; after 3 responses, drain_done pulses for one cycle; FSM in DISABLED. Assert rst mid-issue → ah_cvalid=0 immediately and outstanding=0.

Source files
------------

// File: rtl/command_issue_control_pkg.sv
// Shared types for the AFU command issue path.
//   - PSL command code constants
//   - command_tag_line_t : per-tag record written to the tag table
//   - afu_state_e        : issue FSM states
//   - cmd_if_out_t       : registered PSL command bus (ah_c* outputs)
package afu_pkg;

  localparam logic [12:0] PSL_CMD_READ_CL_NA = 13'h0A00;
  localparam logic [12:0] PSL_CMD_READ_CL_S  = 13'h0A50;
  localparam logic [12:0] PSL_CMD_WRITE_NA   = 13'h0D00;
  localparam logic [12:0] PSL_CMD_WRITE_MI   = 13'h0D70;

  typedef struct packed {
    logic [7:0]  cmd_type;
    logic [7:0]  cu_id;
    logic [15:0] info;
  } command_tag_line_t;

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_RUN      = 2'd1,
    ST_DRAIN    = 2'd2
  } afu_state_e;

  typedef struct packed {
    logic        cvalid;
    logic [7:0]  ctag;
    logic [12:0] com;
    logic [63:0] cea;
    logic [11:0] csize;
    logic [2:0]  cabt;
  } cmd_if_out_t;

endpackage

// File: rtl/command_issue_control_tag_pool_allocator.sv
// Tag pool: free mask, lowest-free allocation, outstanding count and
// detection of bad frees.
//   alloc_i        : take alloc_tag_o this cycle
//   free_i/tag_i   : release a tag (takes effect next cycle)
//   any_free_o     : at least one tag free
//   alloc_tag_o    : lowest-index free tag (from the registered mask)
//   outstanding_o  : NUM_TAGS - popcount(free mask)
//   range_err_o    : free of a tag >= NUM_TAGS (ignored)
//   dbl_free_err_o : free of a tag already free (ignored)
module tag_pool_allocator #(
  parameter int NUM_TAGS = 32,
  parameter int TAG_W    = 8,
  parameter int CNT_W    = 9
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             alloc_i,
  input  logic             free_i,
  input  logic [TAG_W-1:0] free_tag_i,
  output logic             any_free_o,
  output logic [TAG_W-1:0] alloc_tag_o,
  output logic [CNT_W-1:0] outstanding_o,
  output logic             range_err_o,
  output logic             dbl_free_err_o
);
  localparam int IDX_W = $clog2(NUM_TAGS);

  logic [NUM_TAGS-1:0] free_q, free_d;
  logic [IDX_W-1:0]    alloc_idx, rel_idx;
  logic                in_range, rel_ok;
  logic [CNT_W-1:0]    pop;

  assign any_free_o = |free_q;

  // Walk high to low so the last hit, the lowest index, wins.
  always_comb begin
    alloc_tag_o = '0;
    for (int i = NUM_TAGS - 1; i >= 0; i--)
      if (free_q[i]) alloc_tag_o = TAG_W'(i);
  end

  assign alloc_idx      = alloc_tag_o[IDX_W-1:0];
  assign rel_idx        = free_tag_i[IDX_W-1:0];
  assign in_range       = int'(free_tag_i) < NUM_TAGS;
  assign range_err_o    = free_i && !in_range;
  assign dbl_free_err_o = free_i && in_range && free_q[rel_idx];
  assign rel_ok         = free_i && in_range && !free_q[rel_idx];

  // A released tag is busy this cycle, so it never collides with alloc.
  for (genvar g = 0; g < NUM_TAGS; g++) begin : g_tag
    assign free_d[g] = (free_q[g] & ~(alloc_i & (alloc_idx == IDX_W'(g)))) |
                       (rel_ok & (rel_idx == IDX_W'(g)));
  end

  always_ff @(posedge clock or posedge rst)
    if (rst) free_q <= '1;
    else     free_q <= free_d;

  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_TAGS; i++) pop = pop + CNT_W'(free_q[i]);
  end

  assign outstanding_o = CNT_W'(NUM_TAGS) - pop;

endmodule

// File: rtl/parity.sv
// Odd-parity generator: par_o is chosen so data_i plus par_o has odd weight.
//   data_i [BITS] : protected data
//   par_o         : parity bit
module parity #(
  parameter int BITS = 8
) (
  input  logic [BITS-1:0] data_i,
  output logic            par_o
);
  assign par_o = ~^data_i;
endmodule

// File: rtl/command_issue_control.sv
// PSL command issue: allocates a tag and a credit per AFU request, drives the
// PSL command bus one cycle later with odd parity, writes the tag table, and
// recovers tags/credits from responses. Disabling the AFU drains in-flight tags.
//   clock, rst                : clock, async active-high reset
//   enabled_in, ha_croom      : AFU enable, PSL command room (latched on enable)
//   cmd_*                     : request from the command arbiter (ready/valid)
//   resp_*                    : returned tag and signed credit return
//   ah_c*                     : PSL command bus
//   tag_wr_*                  : tag table write port
//   outstanding, drain_done   : tags in flight, drain complete pulse
//   command_error             : sticky {credit_overflow, tag_double_free, tag_range}
module command_issue_control
  import afu_pkg::*;
#(
  parameter int NUM_TAGS = 32,
  parameter int TAG_W    = 8,
  parameter int CREDIT_W = 9
) (
  input  logic                clock,
  input  logic                rst,
  input  logic                enabled_in,
  input  logic [7:0]          ha_croom,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [12:0]         cmd_com,
  input  logic [63:0]         cmd_ea,
  input  logic [11:0]         cmd_size,
  input  logic [2:0]          cmd_abt,
  input  logic [31:0]         cmd_meta,
  input  logic                resp_valid,
  input  logic [TAG_W-1:0]    resp_tag,
  input  logic [CREDIT_W-1:0] resp_credits,
  output logic                ah_cvalid,
  output logic [TAG_W-1:0]    ah_ctag,
  output logic                ah_ctagpar,
  output logic [12:0]         ah_com,
  output logic                ah_compar,
  output logic [63:0]         ah_cea,
  output logic                ah_ceapar,
  output logic [11:0]         ah_csize,
  output logic [2:0]          ah_cabt,
  output logic [15:0]         ah_cch,
  output logic                tag_wr_en,
  output logic [TAG_W-1:0]    tag_wr_addr,
  output logic [31:0]         tag_wr_data,
  output logic [8:0]          outstanding,
  output logic                drain_done,
  output logic [2:0]          command_error
);
  localparam int CW2 = CREDIT_W + 2;

  afu_state_e                  state_q, state_d;
  logic signed [CREDIT_W-1:0]  credits_q, credits_d;
  logic [CREDIT_W-1:0]         room_q, room_d;
  logic [2:0]                  err_q;
  cmd_if_out_t                 cmd_out_q;
  logic                        tag_wr_en_q;
  logic [TAG_W-1:0]            tag_wr_addr_q;
  command_tag_line_t           tag_wr_data_q;

  logic             issue, latch_room, any_free, ovf, rng_err, dbl_err;
  logic [TAG_W-1:0] alloc_tag;

  // Extended-width credit arithmetic so the sum cannot wrap before the check.
  logic signed [CW2-1:0] cred_cur, cred_ret, cred_room, cred_sum;

  tag_pool_allocator #(
    .NUM_TAGS (NUM_TAGS),
    .TAG_W    (TAG_W),
    .CNT_W    (9)
  ) u_pool (
    .clock          (clock),
    .rst            (rst),
    .alloc_i        (issue),
    .free_i         (resp_valid),
    .free_tag_i     (resp_tag),
    .any_free_o     (any_free),
    .alloc_tag_o    (alloc_tag),
    .outstanding_o  (outstanding),
    .range_err_o    (rng_err),
    .dbl_free_err_o (dbl_err)
  );

  // FSM: state register
  always_ff @(posedge clock or posedge rst)
    if (rst) state_q <= ST_DISABLED;
    else     state_q <= state_d;

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_DISABLED: if (enabled_in)          state_d = ST_RUN;
      ST_RUN:      if (!enabled_in)         state_d = ST_DRAIN;
      ST_DRAIN:    if (outstanding == '0)   state_d = ST_DISABLED;
      default:                              state_d = ST_DISABLED;
    endcase
  end

  // FSM: outputs
  always_comb begin
    cmd_ready  = 1'b0;
    drain_done = 1'b0;
    latch_room = 1'b0;
    unique case (state_q)
      ST_DISABLED: latch_room = enabled_in;
      ST_RUN:      cmd_ready  = !credits_q[CREDIT_W-1] && (credits_q != '0) && any_free;
      ST_DRAIN:    drain_done = (outstanding == '0);
      default:     ;
    endcase
  end

  assign issue = cmd_valid && cmd_ready;

  // Credits
  assign cred_cur  = {{2{credits_q[CREDIT_W-1]}}, credits_q};
  assign cred_ret  = resp_valid ? {{2{resp_credits[CREDIT_W-1]}}, resp_credits} : '0;
  assign cred_room = {2'b00, room_q};
  assign cred_sum  = cred_cur - {{(CW2-1){1'b0}}, issue} + cred_ret;

  always_comb begin
    room_d    = room_q;
    credits_d = cred_sum[CREDIT_W-1:0];
    ovf       = 1'b0;
    if (latch_room) begin
      room_d    = CREDIT_W'(ha_croom);
      credits_d = CREDIT_W'(ha_croom);
    end else if (cred_sum > cred_room) begin
      ovf       = 1'b1;
      credits_d = room_q;
    end
  end

  always_ff @(posedge clock or posedge rst)
    if (rst) begin
      credits_q <= '0;
      room_q    <= '0;
      err_q     <= '0;
    end else begin
      credits_q <= credits_d;
      room_q    <= room_d;
      err_q     <= err_q | {ovf, dbl_err, rng_err};
    end

  // Command bus and tag table: one-cycle registered issue. Fields hold
  // between issues; only the strobes return to zero.
  always_ff @(posedge clock or posedge rst)
    if (rst) begin
      cmd_out_q     <= '0;
      tag_wr_en_q   <= 1'b0;
      tag_wr_addr_q <= '0;
      tag_wr_data_q <= '0;
    end else begin
      cmd_out_q.cvalid <= issue;
      tag_wr_en_q      <= issue;
      if (issue) begin
        cmd_out_q.ctag  <= 8'(alloc_tag);
        cmd_out_q.com   <= cmd_com;
        cmd_out_q.cea   <= cmd_ea;
        cmd_out_q.csize <= cmd_size;
        cmd_out_q.cabt  <= cmd_abt;
        tag_wr_addr_q   <= alloc_tag;
        tag_wr_data_q   <= command_tag_line_t'(cmd_meta);
      end
    end

  parity #(.BITS(8))  u_par_tag (.data_i(cmd_out_q.ctag), .par_o(ah_ctagpar));
  parity #(.BITS(13)) u_par_com (.data_i(cmd_out_q.com),  .par_o(ah_compar));
  parity #(.BITS(64)) u_par_ea  (.data_i(cmd_out_q.cea),  .par_o(ah_ceapar));

  assign ah_cvalid     = cmd_out_q.cvalid;
  assign ah_ctag       = TAG_W'(cmd_out_q.ctag);
  assign ah_com        = cmd_out_q.com;
  assign ah_cea        = cmd_out_q.cea;
  assign ah_csize      = cmd_out_q.csize;
  assign ah_cabt       = cmd_out_q.cabt;
  assign ah_cch        = '0;
  assign tag_wr_en     = tag_wr_en_q;
  assign tag_wr_addr   = tag_wr_addr_q;
  assign tag_wr_data   = tag_wr_data_q;
  assign command_error = err_q;

endmodule

// File: tb/tb_command_issue_control.sv
module tb_command_issue_control;
  import afu_pkg::*;

  logic        clock = 1'b0;
  logic        rst;
  logic        enabled_in;
  logic [7:0]  ha_croom;
  logic        cmd_valid, cmd_ready;
  logic [12:0] cmd_com;
  logic [63:0] cmd_ea;
  logic [11:0] cmd_size;
  logic [2:0]  cmd_abt;
  logic [31:0] cmd_meta;
  logic        resp_valid;
  logic [7:0]  resp_tag;
  logic [8:0]  resp_credits;
  logic        ah_cvalid, ah_ctagpar, ah_compar, ah_ceapar;
  logic [7:0]  ah_ctag;
  logic [12:0] ah_com;
  logic [63:0] ah_cea;
  logic [11:0] ah_csize;
  logic [2:0]  ah_cabt;
  logic [15:0] ah_cch;
  logic        tag_wr_en;
  logic [7:0]  tag_wr_addr;
  logic [31:0] tag_wr_data;
  logic [8:0]  outstanding;
  logic        drain_done;
  logic [2:0]  command_error;

  command_issue_control dut (
    .clock(clock), .rst(rst), .enabled_in(enabled_in), .ha_croom(ha_croom),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_com(cmd_com),
    .cmd_ea(cmd_ea), .cmd_size(cmd_size), .cmd_abt(cmd_abt), .cmd_meta(cmd_meta),
    .resp_valid(resp_valid), .resp_tag(resp_tag), .resp_credits(resp_credits),
    .ah_cvalid(ah_cvalid), .ah_ctag(ah_ctag), .ah_ctagpar(ah_ctagpar),
    .ah_com(ah_com), .ah_compar(ah_compar), .ah_cea(ah_cea),
    .ah_ceapar(ah_ceapar), .ah_csize(ah_csize), .ah_cabt(ah_cabt),
    .ah_cch(ah_cch), .tag_wr_en(tag_wr_en), .tag_wr_addr(tag_wr_addr),
    .tag_wr_data(tag_wr_data), .outstanding(outstanding),
    .drain_done(drain_done), .command_error(command_error)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        en;
    logic [7:0]  croom;
    logic        cv;
    logic [12:0] com;
    logic [63:0] ea;
    logic        rv;
    logic [7:0]  rtag;
    logic [8:0]  rcr;
    logic        x_rdy;   // cmd_ready before the edge
    logic        x_cv;    // ah_cvalid after the edge
    logic [7:0]  x_tag;
    logic [2:0]  x_par;   // {tagpar, compar, ceapar}
    logic [8:0]  x_out;
    logic        x_drain;
    logic [2:0]  x_err;
  } vec_t;

  function automatic vec_t mk(
    input logic en, input logic [7:0] croom, input logic cv, input logic [12:0] com,
    input logic [63:0] ea, input logic rv, input logic [7:0] rtag, input logic [8:0] rcr,
    input logic x_rdy, input logic x_cv, input logic [7:0] x_tag, input logic [2:0] x_par,
    input logic [8:0] x_out, input logic x_drain, input logic [2:0] x_err);
    vec_t v;
    v.en = en; v.croom = croom; v.cv = cv; v.com = com; v.ea = ea;
    v.rv = rv; v.rtag = rtag; v.rcr = rcr; v.x_rdy = x_rdy; v.x_cv = x_cv;
    v.x_tag = x_tag; v.x_par = x_par; v.x_out = x_out; v.x_drain = x_drain;
    v.x_err = x_err;
    return v;
  endfunction

  localparam int NV = 29;
  vec_t tv [NV];

  localparam logic [12:0] RD = PSL_CMD_READ_CL_NA;  // 0x0A00, even weight
  localparam logic [12:0] WR = PSL_CMD_WRITE_NA;    // 0x0D00, odd weight
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  initial begin
    //        en croom cv com ea          rv tag  cr    rdy cv tag par     out dr err
    tv[0]  = mk(1, 4, 0, RD, 64'h0,      0, 0,  9'd0, 0, 0, 0, 3'b000, 0, 0, 3'b000);
    tv[1]  = mk(1, 4, 1, RD, 64'h1,      0, 0,  9'd0, 1, 1, 0, 3'b110, 1, 0, 3'b000);
    tv[2]  = mk(1, 4, 1, RD, 64'h40,     0, 0,  9'd0, 1, 1, 1, 3'b010, 2, 0, 3'b000);
    tv[3]  = mk(1, 4, 1, RD, 64'h80,     0, 0,  9'd0, 1, 1, 2, 3'b010, 3, 0, 3'b000);
    tv[4]  = mk(1, 4, 1, RD, 64'hC0,     0, 0,  9'd0, 1, 1, 3, 3'b111, 4, 0, 3'b000);
    tv[5]  = mk(1, 4, 1, RD, 64'h0,      0, 0,  9'd0, 0, 0, 0, 3'b000, 4, 0, 3'b000);
    tv[6]  = mk(1, 4, 0, RD, 64'h0,      1, 1,  9'd1, 0, 0, 0, 3'b000, 3, 0, 3'b000);
    tv[7]  = mk(1, 4, 0, RD, 64'h0,      1, 2,  9'd0, 1, 0, 0, 3'b000, 2, 0, 3'b000);
    tv[8]  = mk(1, 4, 0, RD, 64'h0,      1, 3,  9'd0, 1, 0, 0, 3'b000, 1, 0, 3'b000);
    // same-cycle free of tag 0 and allocate: new command takes tag 1
    tv[9]  = mk(1, 4, 1, WR, 64'h0,      1, 0,  9'd1, 1, 1, 1, 3'b001, 1, 0, 3'b000);
    tv[10] = mk(1, 4, 1, WR, 64'h0,      0, 0,  9'd0, 1, 1, 0, 3'b101, 2, 0, 3'b000);
    tv[11] = mk(1, 4, 1, RD, 64'h0,      0, 0,  9'd0, 0, 0, 0, 3'b000, 2, 0, 3'b000);
    // errors: range, double free, overflow (credits clamp to room 4)
    tv[12] = mk(1, 4, 0, RD, 64'h0,      1, 40, 9'd0, 0, 0, 0, 3'b000, 2, 0, 3'b001);
    tv[13] = mk(1, 4, 0, RD, 64'h0,      1, 2,  9'd0, 0, 0, 0, 3'b000, 2, 0, 3'b011);
    tv[14] = mk(1, 4, 0, RD, 64'h0,      1, 1,  9'd4, 0, 0, 0, 3'b000, 1, 0, 3'b011);
    tv[15] = mk(1, 4, 0, RD, 64'h0,      1, 0,  9'd5, 1, 0, 0, 3'b000, 0, 0, 3'b111);
    tv[16] = mk(1, 4, 1, RD, ONES,       0, 0,  9'd0, 1, 1, 0, 3'b111, 1, 0, 3'b111);
    tv[17] = mk(1, 4, 1, RD, ONES,       0, 0,  9'd0, 1, 1, 1, 3'b011, 2, 0, 3'b111);
    tv[18] = mk(1, 4, 1, RD, ONES,       0, 0,  9'd0, 1, 1, 2, 3'b011, 3, 0, 3'b111);
    tv[19] = mk(1, 4, 1, RD, ONES,       0, 0,  9'd0, 1, 1, 3, 3'b111, 4, 0, 3'b111);
    tv[20] = mk(1, 4, 1, RD, 64'h0,      0, 0,  9'd0, 0, 0, 0, 3'b000, 4, 0, 3'b111);
    // drain with 3 outstanding
    tv[21] = mk(1, 4, 0, RD, 64'h0,      1, 3,  9'd1, 0, 0, 0, 3'b000, 3, 0, 3'b111);
    tv[22] = mk(0, 4, 0, RD, 64'h0,      0, 0,  9'd0, 1, 0, 0, 3'b000, 3, 0, 3'b111);
    tv[23] = mk(0, 4, 1, RD, 64'h0,      1, 0,  9'd0, 0, 0, 0, 3'b000, 2, 0, 3'b111);
    tv[24] = mk(0, 4, 0, RD, 64'h0,      1, 1,  9'd0, 0, 0, 0, 3'b000, 1, 0, 3'b111);
    tv[25] = mk(0, 4, 0, RD, 64'h0,      1, 2,  9'd0, 0, 0, 0, 3'b000, 0, 1, 3'b111);
    tv[26] = mk(0, 4, 1, RD, 64'h0,      0, 0,  9'd0, 0, 0, 0, 3'b000, 0, 0, 3'b111);
    tv[27] = mk(1, 2, 0, RD, 64'h0,      0, 0,  9'd0, 0, 0, 0, 3'b000, 0, 0, 3'b111);
    tv[28] = mk(1, 2, 1, RD, 64'h3,      0, 0,  9'd0, 1, 1, 0, 3'b111, 1, 0, 3'b111);

    rst = 1'b1; enabled_in = 0; ha_croom = 0; cmd_valid = 0; cmd_com = 0;
    cmd_ea = 0; cmd_size = 12'h080; cmd_abt = 3'b010; cmd_meta = 0;
    resp_valid = 0; resp_tag = 0; resp_credits = 0;
    #1;
    chk("rst cvalid", 64'(ah_cvalid), 0);
    chk("rst par",    64'({ah_ctagpar, ah_compar, ah_ceapar}), 64'h7);
    chk("rst ready",  64'(cmd_ready), 0);
    chk("rst out",    64'(outstanding), 0);
    chk("rst err",    64'(command_error), 0);
    chk("rst wr_en",  64'(tag_wr_en), 0);
    chk("rst drain",  64'(drain_done), 0);
    repeat (2) @(posedge clock);
    #1 rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      enabled_in = tv[i].en; ha_croom = tv[i].croom; cmd_valid = tv[i].cv;
      cmd_com = tv[i].com; cmd_ea = tv[i].ea; cmd_meta = 32'hC0DE_0000 + i;
      resp_valid = tv[i].rv; resp_tag = tv[i].rtag; resp_credits = tv[i].rcr;
      #1;
      chk($sformatf("row%0d ready", i), 64'(cmd_ready), 64'(tv[i].x_rdy));
      @(posedge clock);
      #1;
      chk($sformatf("row%0d cvalid", i), 64'(ah_cvalid), 64'(tv[i].x_cv));
      chk($sformatf("row%0d wr_en", i), 64'(tag_wr_en), 64'(tv[i].x_cv));
      chk($sformatf("row%0d outstanding", i), 64'(outstanding), 64'(tv[i].x_out));
      chk($sformatf("row%0d drain_done", i), 64'(drain_done), 64'(tv[i].x_drain));
      chk($sformatf("row%0d error", i), 64'(command_error), 64'(tv[i].x_err));
      chk($sformatf("row%0d cch", i), 64'(ah_cch), 0);
      if (tv[i].x_cv) begin
        chk($sformatf("row%0d tag", i), 64'(ah_ctag), 64'(tv[i].x_tag));
        chk($sformatf("row%0d parity", i), 64'({ah_ctagpar, ah_compar, ah_ceapar}), 64'(tv[i].x_par));
        chk($sformatf("row%0d com", i), 64'(ah_com), 64'(tv[i].com));
        chk($sformatf("row%0d ea", i), ah_cea, tv[i].ea);
        chk($sformatf("row%0d size_abt", i), 64'({ah_csize, ah_cabt}), 64'({12'h080, 3'b010}));
        chk($sformatf("row%0d wr_addr", i), 64'(tag_wr_addr), 64'(tv[i].x_tag));
        chk($sformatf("row%0d wr_data", i), 64'(tag_wr_data), 64'(32'hC0DE_0000 + i));
      end
    end

    // Tag exhaustion with large room, then reuse of a single freed tag.
    cmd_valid = 0; resp_valid = 0; resp_credits = 0;
    rst = 1'b1;
    #1;
    chk("rst2 err", 64'(command_error), 0);
    chk("rst2 out", 64'(outstanding), 0);
    @(posedge clock);
    #1 rst = 1'b0; enabled_in = 1; ha_croom = 8'd64;
    @(posedge clock);
    #1;
    for (int k = 0; k < 32; k++) begin
      cmd_valid = 1; cmd_com = RD; cmd_ea = 64'(k);
      @(posedge clock);
      #1 chk($sformatf("exh tag%0d", k), 64'(ah_ctag), 64'(k));
    end
    chk("exh ready", 64'(cmd_ready), 0);
    chk("exh out", 64'(outstanding), 32);
    cmd_valid = 0; resp_valid = 1; resp_tag = 8'd5;
    @(posedge clock);
    #1 resp_valid = 0; cmd_valid = 1;
    #1 chk("reuse ready", 64'(cmd_ready), 1);
    @(posedge clock);
    #1;
    chk("reuse cvalid", 64'(ah_cvalid), 1);
    chk("reuse tag", 64'(ah_ctag), 5);
    chk("reuse out", 64'(outstanding), 32);

    // Reset landing while a command is on the bus.
    cmd_valid = 0; resp_valid = 1; resp_tag = 8'd6;
    @(posedge clock);
    #1 resp_valid = 0; cmd_valid = 1;
    @(posedge clock);
    #1 chk("pre-rst cvalid", 64'(ah_cvalid), 1);
    #1 rst = 1'b1;
    #1;
    chk("midrst cvalid", 64'(ah_cvalid), 0);
    chk("midrst out", 64'(outstanding), 0);
    chk("midrst wr_en", 64'(tag_wr_en), 0);
    chk("midrst ready", 64'(cmd_ready), 0);
    chk("midrst par", 64'({ah_ctagpar, ah_compar, ah_ceapar}), 64'h7);
    cmd_valid = 0;
    @(posedge clock);
    #1 rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
